// File: rtl/demux_pkg.sv
// Shared types and defaults for the demux8_deser serial-to-parallel receiver.
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH_DFLT = 8;

  typedef enum logic {EMPTY, FULL} out_state_e;

endpackage

// File: rtl/demux8_deser_if.sv
// Serial-in / word-out bus for demux8_deser; out_parity exists only with DEMUX_PARITY_EN.
interface demux8_deser_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DFLT,
  parameter int unsigned SEL_W = $clog2(WIDTH)
);

  logic             in_bit;
  logic             in_valid;
  logic             in_ready;
  logic             sel_load;
  logic [SEL_W-1:0] sel_in;
  logic [SEL_W-1:0] sel_cur;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
`ifdef DEMUX_PARITY_EN
  logic             out_parity;
`endif

  modport master (
    output in_bit, in_valid, sel_load, sel_in, out_ready,
    input  in_ready, sel_cur, out, out_valid
`ifdef DEMUX_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_bit, in_valid, sel_load, sel_in, out_ready,
    output in_ready, sel_cur, out, out_valid
`ifdef DEMUX_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/demux_idx_counter.sv
// Write-index counter: wraps WIDTH-1 -> 0 on inc, load overrides, flags the terminal index.
module demux_idx_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [SEL_W-1:0] load_val_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             last_o
);

  logic [SEL_W-1:0] idx_q, idx_d;

  assign last_o = (idx_q == SEL_W'(WIDTH - 1));
  assign idx_o  = idx_q;

  always_comb begin
    idx_d = idx_q;
    if (load_i) begin
      idx_d = load_val_i;
    end else if (inc_i) begin
      idx_d = last_o ? '0 : idx_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/demux8_deser.sv
// Serial-to-parallel demux: steers bit k of a stream into out[k], presents words on valid/ready.
// Optional even parity output enabled by defining DEMUX_PARITY_EN.
module demux8_deser
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH_DFLT
) (
  input  logic          clk,
  input  logic          rst,
  demux8_deser_if.slave demux_io
);

  localparam int unsigned SEL_W = $clog2(WIDTH);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] asm_q, asm_d, asm_set;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx;
  logic             idx_last;
  logic             in_ready;
  logic             accept;
  logic             word_done;
  logic             out_valid;

  // Only the completing bit has to wait for an unconsumed previous word.
  assign in_ready  = !demux_io.sel_load && !(out_valid && !demux_io.out_ready && idx_last);
  assign accept    = demux_io.in_valid && in_ready;
  assign word_done = accept && idx_last;

  demux_idx_counter #(
    .WIDTH (WIDTH)
  ) u_idx (
    .clk        (clk),
    .rst        (rst),
    .inc_i      (accept),
    .load_i     (demux_io.sel_load),
    .load_val_i (demux_io.sel_in),
    .idx_o      (idx),
    .last_o     (idx_last)
  );

  always_comb begin
    asm_set      = asm_q;
    asm_set[idx] = demux_io.in_bit;
    asm_d        = asm_q;
    out_d        = out_q;
    if (demux_io.sel_load) begin
      asm_d = '0;
    end else if (accept) begin
      asm_d = idx_last ? '0 : asm_set;
    end
    if (word_done) begin
      out_d = asm_set;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q <= '0;
      out_q <= '0;
    end else begin
      asm_q <= asm_d;
      out_q <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (word_done) state_d = FULL;
      FULL:  if (!word_done && demux_io.out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q == FULL);
  end

`ifdef DEMUX_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = word_done ? ^asm_set : parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign demux_io.out_parity = parity_q;
`endif

  assign demux_io.in_ready  = in_ready;
  assign demux_io.sel_cur   = idx;
  assign demux_io.out       = out_q;
  assign demux_io.out_valid = out_valid;

endmodule

// File: tb/tb_demux8_deser.sv
// Bench for demux8_deser: directed scenarios plus random traffic, checked by a word-level
// reference model and a scoreboard of expected words drained by a monitor.
module tb_demux8_deser;
  import demux_pkg::*;

  localparam int W  = 8;
  localparam int SW = $clog2(W);

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux8_deser_if #(.WIDTH(W)) bus ();

  demux8_deser #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .demux_io (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: bit position of next bit, bits gathered so far, presented word.
  int m_idx;
  int m_part;
  int m_out;
  bit m_full;
  int sb_q[$];
  bit last_acc;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int even_par(input int w);
    return $countones(w) & 1;
  endfunction

  // One clock cycle: drive inputs, check DUT state against the model, advance the model.
  task automatic cycle(input bit r, input bit iv, input bit b, input bit sl, input int si,
                       input bit ordy);
    bit exp_ready;
    bit acc;
    bit done;
    @(posedge clk);
    #1;
    rst           = r;
    bus.in_valid  = iv;
    bus.in_bit    = b;
    bus.sel_load  = sl;
    bus.sel_in    = SW'(si);
    bus.out_ready = ordy;
    #1;
    exp_ready = !sl && !(m_full && !ordy && m_idx == W - 1);
    chk("in_ready", int'(bus.in_ready), int'(exp_ready));
    chk("sel_cur", int'(bus.sel_cur), m_idx);
    chk("out_valid", int'(bus.out_valid), int'(m_full));
    chk("out", int'(bus.out), m_out);
`ifdef DEMUX_PARITY_EN
    chk("out_parity", int'(bus.out_parity), even_par(m_out));
`endif
    acc      = iv && exp_ready;
    last_acc = acc;
    done     = 1'b0;
    if (r) begin
      m_idx  = 0;
      m_part = 0;
      m_full = 1'b0;
      m_out  = 0;
      sb_q.delete();
    end else begin
      if (sl) begin
        m_idx  = si;
        m_part = 0;
      end else if (acc) begin
        m_part = m_part | (int'(b) << m_idx);
        if (m_idx == W - 1) begin
          done   = 1'b1;
          m_out  = m_part;
          sb_q.push_back(m_part);
          m_part = 0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
      if (done) m_full = 1'b1;
      else if (m_full && ordy) m_full = 1'b0;
    end
  endtask

  task automatic send_word(input int w, input bit ordy);
    int tries;
    for (int i = 0; i < W; i++) begin
      tries = 0;
      do begin
        cycle(1'b0, 1'b1, w[i], 1'b0, 0, ordy);
        tries++;
      end while (!last_acc && tries < 32);
      chk("bit_accepted", int'(last_acc), 1);
    end
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 0, ordy);
  endtask

  // Monitor: every handshake consumes the oldest expected word.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got word 0x%0h expected no word pending at %0t",
                   bus.out, $time);
        end else begin
          e = sb_q.pop_front();
          chk("sb_word", int'(bus.out), e);
        end
      end
    end
  end

  initial begin
    int a5;
    a5            = 'hA5;
    bus.in_valid  = 1'b0;
    bus.in_bit    = 1'b0;
    bus.sel_load  = 1'b0;
    bus.sel_in    = '0;
    bus.out_ready = 1'b0;
    m_idx  = 0;
    m_part = 0;
    m_full = 1'b0;
    m_out  = 0;
    repeat (2) @(posedge clk);

    // 1: reset, then 0xD6 back-to-back with the consumer ready.
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    send_word('hD6, 1'b1);
    idle(1'b1);
    chk("t1_out", int'(bus.out), 'hD6);
    chk("t1_valid", int'(bus.out_valid), 1);
`ifdef DEMUX_PARITY_EN
    chk("t1_parity", int'(bus.out_parity), 1);
`endif
    idle(1'b1);
    chk("t1_valid_drop", int'(bus.out_valid), 0);

    // 2/3: 0xD6 held, 0xA5 streams; completing bit stalls until out_ready, then no bubble.
    send_word('hD6, 1'b0);
    for (int i = 0; i < W - 1; i++) begin
      cycle(1'b0, 1'b1, a5[i], 1'b0, 0, 1'b0);
      chk("t2_accept", int'(last_acc), 1);
    end
    cycle(1'b0, 1'b1, a5[W-1], 1'b0, 0, 1'b0);
    chk("t2_stall", int'(last_acc), 0);
    chk("t2_hold", int'(bus.out), 'hD6);
    cycle(1'b0, 1'b1, a5[W-1], 1'b0, 0, 1'b1);
    chk("t3_accept", int'(last_acc), 1);
    idle(1'b1);
    chk("t3_out", int'(bus.out), 'hA5);
    chk("t3_valid", int'(bus.out_valid), 1);
    idle(1'b1);

    // 4: re-align mid-word to index 5.
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1);
    chk("t4_load_stall", int'(last_acc), 0);
    idle(1'b1);
    chk("t4_sel_cur", int'(bus.sel_cur), 5);
    repeat (3) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t4_out", int'(bus.out), 'hE0);

    // 5: reset mid-word, then a fresh word.
    repeat (4) cycle(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(1'b1);
    chk("t5_sel_cur", int'(bus.sel_cur), 0);
    chk("t5_valid", int'(bus.out_valid), 0);
    chk("t5_out", int'(bus.out), 0);
    send_word('h3C, 1'b1);
    idle(1'b1);
    chk("t5_word", int'(bus.out), 'h3C);

    // 6: in_valid toggling carries 0xFF.
    for (int i = 0; i < 16; i++) cycle(1'b0, (i % 2) == 0, 1'b1, 1'b0, 0, 1'b1);
    idle(1'b1);
    chk("t6_out", int'(bus.out), 'hFF);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, 1'($urandom),
            $urandom_range(0, 29) == 0, int'($urandom_range(0, W - 1)),
            $urandom_range(0, 9) < 6);
    end

    repeat (3) idle(1'b1);
    chk("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
